// File: rtl/shift_ctr_pkg.sv
// Shared definitions for the parametrised shift-register counter:
// mode/direction encodings, the reset seed, and a width-generic
// legality/position decode used by the RTL decoder.
package shift_ctr_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;

  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic       legal;
    logic [5:0] idx;
  } dec_t;

  // Low thermometer code with k ones; k >= MAX_WIDTH saturates to all ones.
  function automatic logic [MAX_WIDTH-1:0] therm(input int k);
    return (k >= MAX_WIDTH) ? '1 : ((32'd1 << k) - 32'd1);
  endfunction

  // 0...01 for a counter of width w, zero-extended to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] seed(input int w);
    logic [MAX_WIDTH-1:0] s;
    s = '0;
    if (w > 0) s[0] = 1'b1;
    return s;
  endfunction

  // Legality and position of a state v (bits above w must be zero).
  // Ring: one-hot, idx = bit position.
  // Johnson: low thermometer with k ones -> k; the complement of a low
  // thermometer with k zeros at the bottom -> w+k.
  function automatic dec_t decode_state(input logic [MAX_WIDTH-1:0] v,
                                        input int w, input logic m);
    dec_t r;
    logic [MAX_WIDTH-1:0] mask;
    r    = '0;
    mask = therm(w);
    if (m == MODE_RING) begin
      for (int i = 0; i < MAX_WIDTH; i++) begin
        if (i < w && v == (32'd1 << i)) begin
          r.legal = 1'b1;
          r.idx   = 6'(i);
        end
      end
    end else begin
      for (int k = 0; k <= MAX_WIDTH; k++) begin
        if (k <= w && v == therm(k)) begin
          r.legal = 1'b1;
          r.idx   = 6'(k);
        end
        if (k >= 1 && k < w && v == (~therm(k) & mask)) begin
          r.legal = 1'b1;
          r.idx   = 6'(w + k);
        end
      end
    end
    return r;
  endfunction

  function automatic logic state_legal(input logic [MAX_WIDTH-1:0] v,
                                       input int w, input logic m);
    dec_t r;
    r = decode_state(v, w, m);
    return r.legal;
  endfunction

endpackage

// File: rtl/shift_ctr_decode.sv
// Combinational legality check and index decode of the counter state.
// idx is 0 whenever the state is not legal for the registered mode.
module shift_ctr_decode
  import shift_ctr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode_q,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_WIDTH-1:0] q_ext;
  dec_t                 res;

  // Zero-extend the state and decode it with the generic helper.
  always_comb begin
    q_ext              = '0;
    q_ext[WIDTH-1:0]   = q;
    res                = decode_state(q_ext, WIDTH, mode_q);
    legal              = res.legal;
    idx                = IDX_W'(res.idx);
  end

endmodule

// File: rtl/shift_ctr_param.sv
// Parametrised ring/Johnson shift counter with enable, direction,
// synchronous load, decoded index and a registered wrap pulse.
// Build option: SHIFT_CTR_SELF_CORRECT_EN replaces illegal loads and
// illegal states with the seed and pulses err; without it err is 0.
module shift_ctr_param
  import shift_ctr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             illegal,
  output logic             err
);

  localparam logic [MAX_WIDTH-1:0] SEED_EXT  = seed(WIDTH);
  localparam logic [WIDTH-1:0]     SEED      = SEED_EXT[WIDTH-1:0];
  localparam logic [IDX_W-1:0]     LAST_RING = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]     LAST_JOHN = IDX_W'(2*WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shift_up, shift_dn;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             legal;
  logic [IDX_W-1:0] last_idx;

  shift_ctr_decode #(.WIDTH(WIDTH)) u_decode (
    .q      (q_q),
    .mode_q (mode_q),
    .legal  (legal),
    .idx    (idx)
  );

  assign illegal = ~legal;
  assign q       = q_q;
  assign wrap    = wrap_q;

`ifdef SHIFT_CTR_SELF_CORRECT_EN
  logic                 err_q, err_d;
  logic [MAX_WIDTH-1:0] load_ext;
  logic                 load_legal;

  // Legality of the incoming load value against the registered mode.
  always_comb begin
    load_ext            = '0;
    load_ext[WIDTH-1:0] = load_val;
    load_legal          = state_legal(load_ext, WIDTH, mode_q);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Candidate shifted states; Johnson feeds back the inverted end stage.
  always_comb begin
    shift_up = {q_q[WIDTH-2:0], (mode_q == MODE_JOHNSON) ? ~q_q[WIDTH-1] : q_q[WIDTH-1]};
    shift_dn = {(mode_q == MODE_JOHNSON) ? ~q_q[0] : q_q[0], q_q[WIDTH-1:1]};
    last_idx = (mode_q == MODE_JOHNSON) ? LAST_JOHN : LAST_RING;
  end

  // Next state: reseed on mode change, then load, then recovery, then shift.
  always_comb begin
    q_d    = q_q;
    mode_d = mode;
    wrap_d = 1'b0;
`ifdef SHIFT_CTR_SELF_CORRECT_EN
    err_d  = 1'b0;
`endif
    if (mode != mode_q) begin
      q_d = SEED;
    end else if (load) begin
`ifdef SHIFT_CTR_SELF_CORRECT_EN
      if (load_legal) begin
        q_d = load_val;
      end else begin
        q_d   = SEED;
        err_d = 1'b1;
      end
`else
      q_d = load_val;
`endif
    end
`ifdef SHIFT_CTR_SELF_CORRECT_EN
    else if (illegal) begin
      q_d   = SEED;
      err_d = 1'b1;
    end
`endif
    else if (en) begin
      q_d    = (dir == DIR_UP) ? shift_up : shift_dn;
      // Leaving the last index going up, or index 0 going down, wraps.
      wrap_d = legal && (idx == ((dir == DIR_UP) ? last_idx : {IDX_W{1'b0}}));
    end
  end

  // State, mode and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= SEED;
      mode_q <= MODE_RING;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef SHIFT_CTR_SELF_CORRECT_EN
  // Correction pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

endmodule
